// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request, issue and hazard-check signals shared by the ALU, load
// unit and decode stage on one side and regfile_wb_scheduler on the other.
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [2:0]        req0_dest;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [2:0]        req1_dest;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              issue_valid;
    logic [2:0]        issue_dest;
    logic              issue_ready;

    logic [2:0]        chk_src_one;
    logic [2:0]        chk_src_two;
    logic              hazard;

    // Master is the pipeline side (requesters and decode).
    modport master (
        output req0_valid, req0_dest, req0_data,
        output req1_valid, req1_dest, req1_data,
        output issue_valid, issue_dest,
        output chk_src_one, chk_src_two,
        input  req0_ready, req1_ready, issue_ready, hazard
    );

    modport slave (
        input  req0_valid, req0_dest, req0_data,
        input  req1_valid, req1_dest, req1_data,
        input  issue_valid, issue_dest,
        input  chk_src_one, chk_src_two,
        output req0_ready, req1_ready, issue_ready, hazard
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin writeback arbiter, registered register-file write stage and
// pending-write scoreboard. Define WB_BYPASS_EN to add write-stage forwarding.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_scheduler_if.slave wb,
    output logic [2:0]            rf_dest,
    output logic                  rf_write_enable,
    output logic [DATA_W-1:0]     rf_data_in,
    output logic [NREG-1:0]       busy,
    output logic                  wb_err
`ifdef WB_BYPASS_EN
    ,
    output logic                  fwd_one_hit,
    output logic                  fwd_two_hit,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    typedef enum logic {
        PRIO_ALU  = 1'b0,
        PRIO_LOAD = 1'b1
    } prio_t;

    prio_t             prio;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [2:0]        win_dest;
    logic [DATA_W-1:0] win_data;
    logic              issue_set;
    logic [NREG-1:0]   busy_next;
    logic              src_one_pending;
    logic              src_two_pending;

    always_comb begin
        grant0   = wb.req0_valid && (!wb.req1_valid || (prio == PRIO_ALU));
        grant1   = wb.req1_valid && (!wb.req0_valid || (prio == PRIO_LOAD));
        accept   = grant0 || grant1;
        win_dest = grant0 ? wb.req0_dest : wb.req1_dest;
        win_data = grant0 ? wb.req0_data : wb.req1_data;
    end

    assign wb.req0_ready  = grant0;
    assign wb.req1_ready  = grant1;
    assign wb.issue_ready = ~busy[wb.issue_dest];
    assign issue_set      = wb.issue_valid && wb.issue_ready;

    // The commit clear is applied first so a same-cycle issue to that register wins.
    always_comb begin
        busy_next = busy;
        if (rf_write_enable) begin
            busy_next[rf_dest] = 1'b0;
        end
        if (issue_set) begin
            busy_next[wb.issue_dest] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_one_hit     = rf_write_enable && (rf_dest == wb.chk_src_one);
    assign fwd_two_hit     = rf_write_enable && (rf_dest == wb.chk_src_two);
    assign fwd_data        = rf_data_in;
    assign src_one_pending = busy[wb.chk_src_one] && !fwd_one_hit;
    assign src_two_pending = busy[wb.chk_src_two] && !fwd_two_hit;
`else
    assign src_one_pending = busy[wb.chk_src_one];
    assign src_two_pending = busy[wb.chk_src_two];
`endif

    assign wb.hazard = src_one_pending || src_two_pending;

    // The loser of an accepted arbitration becomes the favoured port next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio            <= PRIO_ALU;
            rf_write_enable <= 1'b0;
            rf_dest         <= '0;
            rf_data_in      <= '0;
            busy            <= '0;
            wb_err          <= 1'b0;
        end else begin
            busy            <= busy_next;
            rf_write_enable <= accept;
            if (accept) begin
                rf_dest    <= win_dest;
                rf_data_in <= win_data;
                prio       <= grant0 ? PRIO_LOAD : PRIO_ALU;
                if (!busy[win_dest]) begin
                    wb_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler; follows WB_BYPASS_EN
// when that macro is defined for the build.
module tb_regfile_wb_scheduler;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        rf_dest;
    logic              rf_write_enable;
    logic [DATA_W-1:0] rf_data_in;
    logic [7:0]        busy;
    logic              wb_err;
`ifdef WB_BYPASS_EN
    logic              fwd_one_hit;
    logic              fwd_two_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.DATA_W(DATA_W)) wb_bus ();

    regfile_wb_scheduler #(.DATA_W(DATA_W), .NREG(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb              (wb_bus.slave),
        .rf_dest         (rf_dest),
        .rf_write_enable (rf_write_enable),
        .rf_data_in      (rf_data_in),
        .busy            (busy),
        .wb_err          (wb_err)
`ifdef WB_BYPASS_EN
        ,
        .fwd_one_hit     (fwd_one_hit),
        .fwd_two_hit     (fwd_two_hit),
        .fwd_data        (fwd_data)
`endif
    );

    task automatic apply_stimulus(
        input logic v0, input logic [2:0] d0, input logic [31:0] x0,
        input logic v1, input logic [2:0] d1, input logic [31:0] x1,
        input logic iv, input logic [2:0] id
    );
        wb_bus.req0_valid  = v0;
        wb_bus.req0_dest   = d0;
        wb_bus.req0_data   = x0;
        wb_bus.req1_valid  = v1;
        wb_bus.req1_dest   = d1;
        wb_bus.req1_data   = x1;
        wb_bus.issue_valid = iv;
        wb_bus.issue_dest  = id;
    endtask

    task automatic idle_inputs();
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        wb_bus.chk_src_one = 3'd0;
        wb_bus.chk_src_two = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_output_bit("rst_we", rf_write_enable, 1'b0);
        check_output("rst_dest", 32'(rf_dest), 32'd0);
        check_output("rst_data", rf_data_in, 32'd0);
        check_output("rst_busy", 32'(busy), 32'h00);
        check_output_bit("rst_wb_err", wb_err, 1'b0);
        check_output_bit("rst_hazard", wb_bus.hazard, 1'b0);
        check_output_bit("rst_issue_ready", wb_bus.issue_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Issue r3, then ALU writes DEADBEEF to r3.
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd3);
        #1 check_output_bit("r3_issue_ready", wb_bus.issue_ready, 1'b1);
        tick();
        apply_stimulus(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        #1;
        check_output("r3_busy_set", 32'(busy), 32'h08);
        check_output_bit("r3_ready0", wb_bus.req0_ready, 1'b1);
        check_output_bit("r3_ready1", wb_bus.req1_ready, 1'b0);
        tick();
        idle_inputs();
        #1;
        check_output_bit("r3_we_n1", rf_write_enable, 1'b1);
        check_output("r3_dest_n1", 32'(rf_dest), 32'd3);
        check_output("r3_data_n1", rf_data_in, 32'hDEADBEEF);
        check_output("r3_busy_n1", 32'(busy), 32'h08);
        tick();
        #1;
        check_output("r3_busy_n2", 32'(busy), 32'h00);
        check_output_bit("r3_we_n2", rf_write_enable, 1'b0);
        check_output("r3_data_hold", rf_data_in, 32'hDEADBEEF);

        // Hazard on r5 from issue until two cycles after acceptance.
        wb_bus.chk_src_one = 3'd5;
        wb_bus.chk_src_two = 3'd0;
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5);
        #1 check_output_bit("r5_hazard_pre", wb_bus.hazard, 1'b0);
        tick();
        apply_stimulus(1'b1, 3'd5, 32'h00000055, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        #1;
        check_output_bit("r5_hazard_n", wb_bus.hazard, 1'b1);
        check_output_bit("r5_ready0", wb_bus.req0_ready, 1'b1);
        tick();
        idle_inputs();
        #1;
`ifdef WB_BYPASS_EN
        check_output_bit("r5_hazard_n1_fwd", wb_bus.hazard, 1'b0);
        check_output_bit("r5_fwd_one_hit", fwd_one_hit, 1'b1);
        check_output_bit("r5_fwd_two_hit", fwd_two_hit, 1'b0);
        check_output("r5_fwd_data", fwd_data, 32'h00000055);
`else
        check_output_bit("r5_hazard_n1", wb_bus.hazard, 1'b1);
`endif
        tick();
        #1 check_output_bit("r5_hazard_n2", wb_bus.hazard, 1'b0);

        // Re-issue r5 while its write commits: stalled, bit cleared.
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5);
        tick();
        apply_stimulus(1'b1, 3'd5, 32'h5A5A5A5A, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        #1 check_output_bit("r5c_ready0", wb_bus.req0_ready, 1'b1);
        tick();
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5);
        #1;
        check_output_bit("r5c_issue_ready", wb_bus.issue_ready, 1'b0);
        check_output_bit("r5c_we", rf_write_enable, 1'b1);
        check_output("r5c_dest", 32'(rf_dest), 32'd5);
        tick();
        idle_inputs();
        #1 check_output("r5c_busy", 32'(busy), 32'h00);

        // Both ports valid: prio favours port 1 after the earlier ALU wins.
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd1);
        tick();
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd2);
        tick();
        apply_stimulus(1'b1, 3'd1, 32'hAAAA0001, 1'b1, 3'd2, 32'hBBBB0002, 1'b0, 3'd0);
        #1 check_output("alt_busy", 32'(busy), 32'h06);
        for (int i = 0; i < 4; i++) begin
            check_output_bit("alt_ready1", wb_bus.req1_ready, (i % 2) == 0);
            check_output_bit("alt_ready0", wb_bus.req0_ready, (i % 2) != 0);
            if (i > 0) begin
                check_output("alt_rf_dest", 32'(rf_dest), ((i - 1) % 2 == 0) ? 32'd2 : 32'd1);
            end
            tick();
            #1;
        end
        check_output("alt_last_dest", 32'(rf_dest), 32'd1);
        check_output("alt_last_data", rf_data_in, 32'hAAAA0001);
        check_output_bit("alt_wb_err", wb_err, 1'b1);

        // Asynchronous reset with a write pending in the write stage.
        rst_n = 1'b0;
        #1;
        check_output_bit("mid_rst_we", rf_write_enable, 1'b0);
        check_output("mid_rst_dest", 32'(rf_dest), 32'd0);
        check_output("mid_rst_data", rf_data_in, 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'h00);
        check_output_bit("mid_rst_wb_err", wb_err, 1'b0);
        idle_inputs();
        tick();
        check_output_bit("mid_rst_held_we", rf_write_enable, 1'b0);
        rst_n = 1'b1;
        tick();

        // prio returns to port 0 after reset.
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd1);
        tick();
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd2);
        tick();
        apply_stimulus(1'b1, 3'd1, 32'h00000011, 1'b1, 3'd2, 32'h00000022, 1'b0, 3'd0);
        #1;
        check_output_bit("prio_ready0", wb_bus.req0_ready, 1'b1);
        check_output_bit("prio_ready1", wb_bus.req1_ready, 1'b0);
        tick();
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 3'd2, 32'h00000022, 1'b0, 3'd0);
        #1;
        check_output_bit("prio_ready1_next", wb_bus.req1_ready, 1'b1);
        check_output("prio_dest1", 32'(rf_dest), 32'd1);
        check_output("prio_data1", rf_data_in, 32'h00000011);
        tick();
        idle_inputs();
        #1;
        check_output("prio_dest2", 32'(rf_dest), 32'd2);
        check_output("prio_data2", rf_data_in, 32'h00000022);
        check_output_bit("prio_wb_err", wb_err, 1'b0);
        tick();
        #1 check_output("prio_busy", 32'(busy), 32'h00);

        // Load unit writes r7 while it is not busy.
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b1, 3'd7, 32'h77777777, 1'b0, 3'd0);
        #1 check_output_bit("r7_ready1", wb_bus.req1_ready, 1'b1);
        tick();
        idle_inputs();
        #1;
        check_output_bit("r7_we", rf_write_enable, 1'b1);
        check_output("r7_dest", 32'(rf_dest), 32'd7);
        check_output("r7_data", rf_data_in, 32'h77777777);
        check_output_bit("r7_wb_err", wb_err, 1'b1);
        repeat (3) tick();
        check_output_bit("r7_wb_err_sticky", wb_err, 1'b1);

        // Issue r6 in the cycle its write commits: set wins.
        apply_stimulus(1'b1, 3'd6, 32'h00000066, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0);
        tick();
        apply_stimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd6);
        #1;
        check_output_bit("r6_issue_ready", wb_bus.issue_ready, 1'b1);
        check_output_bit("r6_we", rf_write_enable, 1'b1);
        check_output("r6_dest", 32'(rf_dest), 32'd6);
        tick();
        idle_inputs();
        #1;
        check_output("r6_busy", 32'(busy), 32'h40);
        check_output_bit("r6_wb_err", wb_err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
